afe_phase_scheduler: RTL and testbench

- Operation-mode sequencer for the shared optical front end (LED drivers, DC compensation DAC, PGA, 8-bit ADC).
- Runs after the calibration controller has found the RED and IR settings.
- Each frame time-multiplexes RED, IR and an optional dark (ambient) phase.
- Per phase: applies that channel's DC_Comp/PGA_Gain, waits a settling interval, averages 2^AVG_LOG2 ADC samples, then publishes the result with a one-cycle valid strobe.

---
 rtl/afe_phase_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_afe_phase_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/afe_phase_scheduler.sv
// Frame sequencer for the shared optical front end: RED, IR and optional dark phases,
// each applying its AFE settings, settling, then averaging 2^AVG_LOG2 ADC samples.
module afe_phase_scheduler #(
    parameter int SETTLE_CYC = 3,
    parameter int AVG_LOG2   = 2,
    parameter int DARK_EN    = 1
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] red_dc_comp,
    input  logic [3:0] red_pga,
    input  logic [6:0] ir_dc_comp,
    input  logic [3:0] ir_pga,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] DARK_ADC_Value,
    output logic       red_valid,
    output logic       ir_valid,
    output logic       dark_valid,
    output logic       frame_done,
    output logic       busy
);

    localparam int         ACC_W       = 8 + AVG_LOG2;
    localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYC - 1);
    localparam logic [4:0] SAMPLE_LAST = 5'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE,
        RED_SETTLE,
        RED_SAMPLE,
        IR_SETTLE,
        IR_SAMPLE,
        DARK_SETTLE,
        DARK_SAMPLE
    } state_t;

    state_t             state_q;
    logic [4:0]         cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [6:0]         red_dc_q, ir_dc_q;
    logic [3:0]         red_pga_q, ir_pga_q;
    logic               led_red_q, led_ir_q;
    logic [6:0]         dc_q;
    logic [3:0]         pga_q;
    logic [7:0]         red_val_q, ir_val_q, dark_val_q;
    logic               red_valid_q, ir_valid_q, dark_valid_q, frame_done_q, busy_q;

    logic               is_settle, is_sample, settle_done, last_sample;
    logic               frame_end, start_frame;
    logic [ACC_W-1:0]   acc_sum;
    logic [7:0]         avg;

    always_comb begin
        is_settle   = (state_q == RED_SETTLE) || (state_q == IR_SETTLE) || (state_q == DARK_SETTLE);
        is_sample   = (state_q == RED_SAMPLE) || (state_q == IR_SAMPLE) || (state_q == DARK_SAMPLE);
        settle_done = is_settle && (cnt_q == SETTLE_LAST);
        last_sample = is_sample && (cnt_q == SAMPLE_LAST);
        acc_sum     = acc_q + ACC_W'(ADC);
        avg         = 8'(acc_sum >> AVG_LOG2);
        frame_end   = last_sample &&
                      ((state_q == DARK_SAMPLE) || ((state_q == IR_SAMPLE) && (DARK_EN == 0)));
        start_frame = enable && ((state_q == IDLE) || frame_end);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            red_dc_q     <= '0;
            ir_dc_q      <= '0;
            red_pga_q    <= '0;
            ir_pga_q     <= '0;
            led_red_q    <= 1'b0;
            led_ir_q     <= 1'b0;
            dc_q         <= '0;
            pga_q        <= '0;
            red_val_q    <= '0;
            ir_val_q     <= '0;
            dark_val_q   <= '0;
            red_valid_q  <= 1'b0;
            ir_valid_q   <= 1'b0;
            dark_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            red_valid_q  <= 1'b0;
            ir_valid_q   <= 1'b0;
            dark_valid_q <= 1'b0;
            frame_done_q <= 1'b0;

            if (is_settle) begin
                if (settle_done) begin
                    cnt_q <= '0;
                    case (state_q)
                        RED_SETTLE: state_q <= RED_SAMPLE;
                        IR_SETTLE:  state_q <= IR_SAMPLE;
                        default:    state_q <= DARK_SAMPLE;
                    endcase
                end else begin
                    cnt_q <= cnt_q + 5'd1;
                end
            end

            if (is_sample) begin
                if (!last_sample) begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 5'd1;
                end else begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    case (state_q)
                        RED_SAMPLE: begin
                            red_val_q   <= avg;
                            red_valid_q <= 1'b1;
                            state_q     <= IR_SETTLE;
                            led_red_q   <= 1'b0;
                            led_ir_q    <= 1'b1;
                            dc_q        <= ir_dc_q;
                            pga_q       <= ir_pga_q;
                        end
                        IR_SAMPLE: begin
                            ir_val_q   <= avg;
                            ir_valid_q <= 1'b1;
                            led_red_q  <= 1'b0;
                            led_ir_q   <= 1'b0;
                            if (DARK_EN != 0) begin
                                // Dark phase keeps the IR front-end settings, LEDs off.
                                state_q <= DARK_SETTLE;
                            end else begin
                                frame_done_q <= 1'b1;
                                state_q      <= IDLE;
                                busy_q       <= 1'b0;
                                dc_q         <= '0;
                                pga_q        <= '0;
                            end
                        end
                        default: begin
                            dark_val_q   <= avg;
                            dark_valid_q <= 1'b1;
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                            led_red_q    <= 1'b0;
                            led_ir_q     <= 1'b0;
                            dc_q         <= '0;
                            pga_q        <= '0;
                        end
                    endcase
                end
            end

            // A new frame overrides the frame-end return to IDLE for back-to-back operation.
            if (start_frame) begin
                state_q   <= RED_SETTLE;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                acc_q     <= '0;
                red_dc_q  <= red_dc_comp;
                red_pga_q <= red_pga;
                ir_dc_q   <= ir_dc_comp;
                ir_pga_q  <= ir_pga;
                led_red_q <= 1'b1;
                led_ir_q  <= 1'b0;
                dc_q      <= red_dc_comp;
                pga_q     <= red_pga;
            end
        end
    end

    assign LED_RED        = led_red_q;
    assign LED_IR         = led_ir_q;
    assign DC_Comp        = dc_q;
    assign PGA_Gain       = pga_q;
    assign RED_ADC_Value  = red_val_q;
    assign IR_ADC_Value   = ir_val_q;
    assign DARK_ADC_Value = dark_val_q;
    assign red_valid      = red_valid_q;
    assign ir_valid       = ir_valid_q;
    assign dark_valid     = dark_valid_q;
    assign frame_done     = frame_done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_afe_phase_scheduler.sv
// Scoreboard bench: a default instance (with dark phase) and a DARK_EN=0 instance.
module tb_afe_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic [6:0] red_dc = '0, ir_dc = '0;
    logic [3:0] red_pga = '0, ir_pga = '0;
    logic [7:0] adc = '0;

    logic       led_red0, led_ir0, rv0, iv0, dv0, fd0, busy0;
    logic [6:0] dc0;
    logic [3:0] pga0;
    logic [7:0] rval0, ival0, dval0;
    logic       led_red1, led_ir1, rv1, iv1, dv1, fd1, busy1;
    logic [6:0] dc1;
    logic [3:0] pga1;
    logic [7:0] rval1, ival1, dval1;

    afe_phase_scheduler dut0 (
        .CLK(clk), .rst(rst), .enable(en0),
        .red_dc_comp(red_dc), .red_pga(red_pga), .ir_dc_comp(ir_dc), .ir_pga(ir_pga), .ADC(adc),
        .LED_RED(led_red0), .LED_IR(led_ir0), .DC_Comp(dc0), .PGA_Gain(pga0),
        .RED_ADC_Value(rval0), .IR_ADC_Value(ival0), .DARK_ADC_Value(dval0),
        .red_valid(rv0), .ir_valid(iv0), .dark_valid(dv0), .frame_done(fd0), .busy(busy0)
    );

    afe_phase_scheduler #(.SETTLE_CYC(3), .AVG_LOG2(2), .DARK_EN(0)) dut1 (
        .CLK(clk), .rst(rst), .enable(en1),
        .red_dc_comp(red_dc), .red_pga(red_pga), .ir_dc_comp(ir_dc), .ir_pga(ir_pga), .ADC(adc),
        .LED_RED(led_red1), .LED_IR(led_ir1), .DC_Comp(dc1), .PGA_Gain(pga1),
        .RED_ADC_Value(rval1), .IR_ADC_Value(ival1), .DARK_ADC_Value(dval1),
        .red_valid(rv1), .ir_valid(iv1), .dark_valid(dv1), .frame_done(fd1), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vmask;   // {dark, ir, red}
        logic [7:0] val;
        logic       fd;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int d, input logic [2:0] m, input logic [7:0] v,
                        input logic f, input int c);
        exp_t e;
        e.vmask = m;
        e.val   = v;
        e.fd    = f;
        e.cyc   = c;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic [2:0] vm, input logic f,
                       input logic [7:0] rv, input logic [7:0] iv, input logic [7:0] dv,
                       input logic lr, input logic li);
        exp_t e;
        logic [7:0] act;
        checks++;
        if (lr && li) begin
            errors++;
            $display("FAIL led_excl dut%0d both LEDs high at cycle %0d", d, cyc);
        end
        if (vm != 3'b000 || f) begin
            checks++;
            act = vm[0] ? rv : (vm[1] ? iv : dv);
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL txn dut%0d unexpected output mask=%b fd=%b val=%0d cycle=%0d",
                         d, vm, f, act, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (vm !== e.vmask || act !== e.val || f !== e.fd || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL txn dut%0d actual mask=%b val=%0d fd=%b cycle=%0d required mask=%b val=%0d fd=%b cycle=%0d",
                             d, vm, act, f, cyc, e.vmask, e.val, e.fd, e.cyc);
                end else begin
                    $display("txn dut%0d ok mask=%b val=%0d fd=%b cycle=%0d", d, vm, act, f, cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, {dv0, iv0, rv0}, fd0, rval0, ival0, dval0, led_red0, led_ir0);
        mon(1, {dv1, iv1, rv1}, fd1, rval1, ival1, dval1, led_red1, led_ir1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_drive(input string tag, input logic lr, input logic li,
                             input logic [6:0] dc, input logic [3:0] pga, input logic bz,
                             input int e_lr, input int e_li, input int e_dc, input int e_pga,
                             input int e_bz);
        chk({tag, " led_red"}, int'(lr), e_lr);
        chk({tag, " led_ir"}, int'(li), e_li);
        chk({tag, " dc_comp"}, int'(dc), e_dc);
        chk({tag, " pga_gain"}, int'(pga), e_pga);
        chk({tag, " busy"}, int'(bz), e_bz);
    endtask

    task automatic wait_edge(input int k);
        if (k < cyc) begin
            errors++;
            $display("FAIL schedule target=%0d already passed cycle=%0d", k, cyc);
        end
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s, t, u, v;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_drive("reset dut0", led_red0, led_ir0, dc0, pga0, busy0, 0, 0, 0, 0, 0);
        chk_drive("reset dut1", led_red1, led_ir1, dc1, pga1, busy1, 0, 0, 0, 0, 0);
        chk("reset results", int'({rval0, ival0, dval0}), 0);

        // Frame A: constant ADC=100, then back-to-back frame B.
        red_dc = 7'd44; red_pga = 4'd5; ir_dc = 7'd20; ir_pga = 4'd3; adc = 8'd100;
        s = cyc + 1;
        en0 = 1'b1;
        push(0, 3'b001, 8'd100, 1'b0, s + 7);
        push(0, 3'b010, 8'd100, 1'b0, s + 14);
        push(0, 3'b100, 8'd100, 1'b1, s + 21);
        wait_edge(s);
        chk_drive("A red", led_red0, led_ir0, dc0, pga0, busy0, 1, 0, 44, 5, 1);
        wait_edge(s + 7);
        chk_drive("A ir", led_red0, led_ir0, dc0, pga0, busy0, 0, 1, 20, 3, 1);
        wait_edge(s + 10);
        red_pga = 4'd9;
        wait_edge(s + 21);
        chk_drive("B red", led_red0, led_ir0, dc0, pga0, busy0, 1, 0, 44, 9, 1);
        push(0, 3'b001, 8'd25, 1'b0, s + 28);
        push(0, 3'b010, 8'd100, 1'b0, s + 35);
        push(0, 3'b100, 8'd7, 1'b1, s + 42);
        wait_edge(s + 24); adc = 8'd10;
        wait_edge(s + 25); adc = 8'd20; en0 = 1'b0;
        wait_edge(s + 26); adc = 8'd30;
        wait_edge(s + 27); adc = 8'd41;
        wait_edge(s + 28); adc = 8'd100;
        chk("B red value", int'(rval0), 25);
        wait_edge(s + 35); adc = 8'd7;
        wait_edge(s + 36);
        chk_drive("B dark", led_red0, led_ir0, dc0, pga0, busy0, 0, 0, 20, 3, 1);
        wait_edge(s + 42);
        chk_drive("B end", led_red0, led_ir0, dc0, pga0, busy0, 0, 0, 0, 0, 0);
        wait_edge(s + 44);
        chk("idle hold busy", int'(busy0), 0);
        chk("red value hold", int'(rval0), 25);

        // Frame C: reset during IR_SAMPLE aborts the frame without an IR result.
        adc = 8'd100;
        t = cyc + 1;
        en0 = 1'b1;
        push(0, 3'b001, 8'd100, 1'b0, t + 7);
        wait_edge(t + 11);
        rst = 1'b1; en0 = 1'b0;
        wait_edge(t + 12);
        rst = 1'b0;
        chk_drive("C reset", led_red0, led_ir0, dc0, pga0, busy0, 0, 0, 0, 0, 0);
        chk("C reset red value", int'(rval0), 0);
        chk("C reset ir valid", int'(iv0), 0);

        // Frame D: clean restart after reset.
        wait_edge(t + 14);
        adc = 8'd60;
        u = cyc + 1;
        en0 = 1'b1;
        push(0, 3'b001, 8'd60, 1'b0, u + 7);
        push(0, 3'b010, 8'd60, 1'b0, u + 14);
        push(0, 3'b100, 8'd60, 1'b1, u + 21);
        wait_edge(u);
        en0 = 1'b0;
        chk_drive("D red", led_red0, led_ir0, dc0, pga0, busy0, 1, 0, 44, 9, 1);
        wait_edge(u + 22);
        chk_drive("D end", led_red0, led_ir0, dc0, pga0, busy0, 0, 0, 0, 0, 0);
        chk("D dark value", int'(dval0), 60);

        // No-dark instance: frame ends after IR at 14 cycles.
        adc = 8'd150;
        v = cyc + 1;
        en1 = 1'b1;
        push(1, 3'b001, 8'd150, 1'b0, v + 7);
        push(1, 3'b010, 8'd200, 1'b1, v + 14);
        wait_edge(v);
        en1 = 1'b0;
        chk_drive("E red", led_red1, led_ir1, dc1, pga1, busy1, 1, 0, 44, 9, 1);
        wait_edge(v + 7);
        adc = 8'd200;
        chk_drive("E ir", led_red1, led_ir1, dc1, pga1, busy1, 0, 1, 20, 3, 1);
        wait_edge(v + 15);
        chk_drive("E end", led_red1, led_ir1, dc1, pga1, busy1, 0, 0, 0, 0, 0);
        wait_edge(v + 26);
        chk("E dark value", int'(dval1), 0);

        chk("dut0 pending", q0.size(), 0);
        chk("dut1 pending", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
